// File: rtl/adc_pkg.sv
// adc_pkg: widths and sample-format helpers shared by the quad ADC stages.
package adc_pkg;

  localparam int unsigned ADC_WIDTH    = 14;
  localparam int unsigned SAMPLE_WIDTH = 16;
  localparam int unsigned AXIS_WIDTH   = 32;

  // Offset-binary to two's complement: flip the MSB, then sign-extend it.
  function automatic logic [SAMPLE_WIDTH-1:0] offset_to_signed(input logic [ADC_WIDTH-1:0] s);
    logic msb;
    msb = ~s[ADC_WIDTH-1];
    return {{(SAMPLE_WIDTH-ADC_WIDTH+1){msb}}, s[ADC_WIDTH-2:0]};
  endfunction

endpackage

// File: rtl/adc_sample_packer_if.sv
// adc_sample_packer_if: AXI-Stream output bundle of the sample packer.
interface adc_sample_packer_if;
  import adc_pkg::*;

  logic [AXIS_WIDTH-1:0] M_AXIS_TDATA;
  logic                  M_AXIS_TVALID;
  logic                  M_AXIS_TREADY;
  logic                  M_AXIS_TLAST;

  modport master (
    output M_AXIS_TDATA,
    output M_AXIS_TVALID,
    output M_AXIS_TLAST,
    input  M_AXIS_TREADY
  );

  modport slave (
    input  M_AXIS_TDATA,
    input  M_AXIS_TVALID,
    input  M_AXIS_TLAST,
    output M_AXIS_TREADY
  );

endinterface

// File: rtl/adc_word_fifo.sv
// adc_word_fifo: synchronous first-word-fall-through FIFO. A push into a full
// FIFO is still accepted when a pop happens in the same cycle. Pointers carry
// one extra wrap bit so full and empty are told apart by the MSB.
module adc_word_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             push_ok_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             full_s;
  logic             do_pop_s;
  logic             do_push_s;

  assign empty_o   = (wr_q == rd_q);
  assign full_s    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop_s  = pop_i & ~empty_o;
  assign do_push_s = push_i & (~full_s | do_pop_s);
  assign push_ok_o = do_push_s;
  assign rd_data_o = mem_q[rd_q[AW-1:0]];

  // Pointer next-state: advance on accepted push / pop.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push_s) begin
      wr_d = wr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_d = rd_q;
    end
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/adc_sample_packer.sv
// adc_sample_packer: converts 14-bit offset-binary ADC samples to signed
// 16-bit, pairs them into 32-bit words, buffers them in a small FIFO and
// frames them into fixed-length AXI-Stream packets with TLAST.
// Optional build macro ADC_SAMPLE_PACKER_DROP_COUNT_EN adds the saturating
// DROP_COUNT output.
module adc_sample_packer
  import adc_pkg::*;
#(
  parameter int unsigned PACKET_WORDS = 64,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                 AXI_CLK,
  input  logic                 RESET_N,
  input  logic                 AXI_DATA_VALID,
  input  logic [ADC_WIDTH-1:0] AXI_CH_X_DATA,
  input  logic                 ENABLE,
  input  logic                 CLEAR_OVERFLOW,
  adc_sample_packer_if.master  m_axis,
  output logic                 OVERFLOW
`ifdef ADC_SAMPLE_PACKER_DROP_COUNT_EN
  ,
  output logic [15:0]          DROP_COUNT
`endif
);

  localparam logic [15:0] PKT_LAST = 16'(PACKET_WORDS - 1);

  logic                    half_q, half_d;
  logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
  logic [SAMPLE_WIDTH-1:0] sample_s;
  logic                    push_s;
  logic [AXIS_WIDTH-1:0]   push_word_s;
  logic                    pop_s;
  logic                    push_ok_s;
  logic                    drop_s;
  logic                    empty_s;
  logic [AXIS_WIDTH-1:0]   rd_data_s;
  logic [15:0]             pkt_q, pkt_d;
  logic                    ovf_q, ovf_d;

  assign sample_s    = offset_to_signed(AXI_CH_X_DATA);
  assign push_word_s = {sample_s, hold_q};
  assign pop_s       = ~empty_s & m_axis.M_AXIS_TREADY;
  assign drop_s      = push_s & ~push_ok_s;

  // Sample pairing: first strobe is held, second one forms a word. Dropping
  // ENABLE discards any half-formed word.
  always_comb begin
    half_d = half_q;
    hold_d = hold_q;
    push_s = 1'b0;
    if (!ENABLE) begin
      half_d = 1'b0;
    end else if (AXI_DATA_VALID) begin
      if (!half_q) begin
        hold_d = sample_s;
        half_d = 1'b1;
      end else begin
        push_s = 1'b1;
        half_d = 1'b0;
      end
    end else begin
      half_d = half_q;
    end
  end

  // Packet position advances only on pops, so drops never shorten a packet.
  always_comb begin
    pkt_d = pkt_q;
    if (pop_s) begin
      if (pkt_q == PKT_LAST) begin
        pkt_d = 16'd0;
      end else begin
        pkt_d = pkt_q + 16'd1;
      end
    end else begin
      pkt_d = pkt_q;
    end
  end

  // Sticky overflow: a drop wins over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (CLEAR_OVERFLOW) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pairing, packet and overflow state registers.
  always_ff @(posedge AXI_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      half_q <= 1'b0;
      hold_q <= '0;
      pkt_q  <= 16'd0;
      ovf_q  <= 1'b0;
    end else begin
      half_q <= half_d;
      hold_q <= hold_d;
      pkt_q  <= pkt_d;
      ovf_q  <= ovf_d;
    end
  end

  adc_word_fifo #(
    .WIDTH (AXIS_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (AXI_CLK),
    .rst_n_i   (RESET_N),
    .push_i    (push_s),
    .wr_data_i (push_word_s),
    .pop_i     (pop_s),
    .rd_data_o (rd_data_s),
    .empty_o   (empty_s),
    .push_ok_o (push_ok_s)
  );

  // TDATA is forced to zero while empty so idle/reset output is clean.
  assign m_axis.M_AXIS_TVALID = ~empty_s;
  assign m_axis.M_AXIS_TDATA  = empty_s ? {AXIS_WIDTH{1'b0}} : rd_data_s;
  assign m_axis.M_AXIS_TLAST  = ~empty_s & (pkt_q == PKT_LAST);
  assign OVERFLOW             = ovf_q;

`ifdef ADC_SAMPLE_PACKER_DROP_COUNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating drop counter; a clear coinciding with a drop leaves one.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (CLEAR_OVERFLOW) begin
      drop_cnt_d = drop_s ? 16'd1 : 16'd0;
    end else if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge AXI_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      drop_cnt_q <= 16'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DROP_COUNT = drop_cnt_q;
`endif

endmodule

// File: tb/tb_adc_sample_packer.sv
// tb_adc_sample_packer: directed bench for adc_sample_packer with
// PACKET_WORDS=4, FIFO_DEPTH=16. Table vectors plus hand-written sequences;
// a pop monitor checks every emitted word and TLAST against a bench model.
module tb_adc_sample_packer;

  localparam int PW = 4;
  localparam int FD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        enable;
  logic        clr;
  logic [13:0] data;
  logic        overflow;
`ifdef ADC_SAMPLE_PACKER_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  adc_sample_packer_if axis ();

  adc_sample_packer #(
    .PACKET_WORDS (PW),
    .FIFO_DEPTH   (FD)
  ) dut (
    .AXI_CLK        (clk),
    .RESET_N        (rst_n),
    .AXI_DATA_VALID (valid),
    .AXI_CH_X_DATA  (data),
    .ENABLE         (enable),
    .CLEAR_OVERFLOW (clr),
    .m_axis         (axis),
    .OVERFLOW       (overflow)
`ifdef ADC_SAMPLE_PACKER_DROP_COUNT_EN
    ,
    .DROP_COUNT     (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] exp_q [$];
  int          pos;
  int          last_cnt;
  logic        mhalf;
  logic [15:0] mheld;
  bit          drop_next;

  typedef struct {
    logic [13:0] a;
    logic [13:0] b;
    logic [31:0] word;
    logic        last;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference conversion: offset-binary value minus mid-scale.
  function automatic logic [15:0] ref_conv(input logic [13:0] s);
    int v;
    v = int'(s) - 8192;
    return v[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [13:0] s);
    data  = s;
    valid = 1'b1;
    if (enable) begin
      if (!mhalf) begin
        mheld = ref_conv(s);
        mhalf = 1'b1;
      end else begin
        if (!drop_next) exp_q.push_back({ref_conv(s), mheld});
        mhalf = 1'b0;
      end
    end
    step();
    valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    mhalf = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic drain(input int max);
    axis.M_AXIS_TREADY = 1'b1;
    for (int i = 0; i < max && exp_q.size() != 0; i++) step();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_tvalid", {31'd0, axis.M_AXIS_TVALID}, 32'd0);
    axis.M_AXIS_TREADY = 1'b0;
  endtask

  // Pop monitor: every handshake must match the model word and packet slot.
  always @(negedge clk) begin
    if (!rst_n) begin
      pos = 0;
    end else if (axis.M_AXIS_TVALID && axis.M_AXIS_TREADY) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", axis.M_AXIS_TDATA, 32'hxxxxxxxx);
      end else begin
        chk("pop_data", axis.M_AXIS_TDATA, exp_q.pop_front());
        chk("pop_last", {31'd0, axis.M_AXIS_TLAST}, {31'd0, (pos == PW - 1)});
        if (axis.M_AXIS_TLAST) last_cnt++;
        pos = (pos + 1) % PW;
      end
    end
  end

  initial begin
    vecs[0] = '{14'h0ABC, 14'h0ABD, 32'hEABDEABC, 1'b0};
    vecs[1] = '{14'h2000, 14'h3FFF, 32'h1FFF0000, 1'b0};
    vecs[2] = '{14'h0000, 14'h1FFF, 32'hFFFFE000, 1'b0};
    vecs[3] = '{14'h3FFF, 14'h2001, 32'h00011FFF, 1'b1};

    rst_n = 1'b0; valid = 1'b0; enable = 1'b1; clr = 1'b0; data = 14'd0;
    axis.M_AXIS_TREADY = 1'b0;
    drop_next = 1'b0; mhalf = 1'b0; mheld = 16'd0; last_cnt = 0;
    step();
    step();
    chk("rst_tvalid", {31'd0, axis.M_AXIS_TVALID}, 32'd0);
    chk("rst_tlast", {31'd0, axis.M_AXIS_TLAST}, 32'd0);
    chk("rst_tdata", axis.M_AXIS_TDATA, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
`ifdef ADC_SAMPLE_PACKER_DROP_COUNT_EN
    chk("rst_drop_count", {16'd0, drop_count}, 32'd0);
`endif
    rst_n = 1'b1;
    step();

    // Latency: TVALID one cycle after the second strobe.
    axis.M_AXIS_TREADY = 1'b1;
    strobe(14'h0ABC);
    chk("lat_tvalid_half", {31'd0, axis.M_AXIS_TVALID}, 32'd0);
    strobe(14'h0ABD);
    chk("lat_tvalid", {31'd0, axis.M_AXIS_TVALID}, 32'd1);
    chk("lat_tdata", axis.M_AXIS_TDATA, 32'hEABDEABC);
    step();
    chk("lat_popped", {31'd0, axis.M_AXIS_TVALID}, 32'd0);
    axis.M_AXIS_TREADY = 1'b0;

    // Table vectors: conversion corners and TLAST on the fourth word.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      strobe(vecs[i].a);
      strobe(vecs[i].b);
    end
    for (int i = 0; i < 4; i++) begin
      chk("vec_tvalid", {31'd0, axis.M_AXIS_TVALID}, 32'd1);
      chk("vec_tdata", axis.M_AXIS_TDATA, vecs[i].word);
      chk("vec_tlast", {31'd0, axis.M_AXIS_TLAST}, {31'd0, vecs[i].last});
      axis.M_AXIS_TREADY = 1'b1;
      step();
      axis.M_AXIS_TREADY = 1'b0;
    end
    chk("vec_done", {31'd0, axis.M_AXIS_TVALID}, 32'd0);

    // Framing: 16 back-to-back samples, ready high, two packets of four.
    do_reset();
    last_cnt = 0;
    axis.M_AXIS_TREADY = 1'b1;
    for (int i = 0; i < 16; i++) strobe(14'(i * 977 + 3));
    drain(20);
    chk("frame_lasts", 32'(last_cnt), 32'd2);

    // Back-pressure: 17th word dropped, first 16 kept in order.
    do_reset();
    last_cnt = 0;
    for (int i = 0; i < 34; i++) begin
      drop_next = (i >= 32);
      strobe(14'(i * 100 + 5));
      if (i == 31) chk("bp_no_ovf_yet", {31'd0, overflow}, 32'd0);
    end
    drop_next = 1'b0;
    chk("bp_overflow", {31'd0, overflow}, 32'd1);
`ifdef ADC_SAMPLE_PACKER_DROP_COUNT_EN
    chk("bp_drop_count", {16'd0, drop_count}, 32'd1);
`endif
    drain(40);
    chk("bp_lasts", 32'(last_cnt), 32'd4);
    chk("bp_ovf_sticky", {31'd0, overflow}, 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("bp_ovf_cleared", {31'd0, overflow}, 32'd0);
`ifdef ADC_SAMPLE_PACKER_DROP_COUNT_EN
    chk("bp_dc_cleared", {16'd0, drop_count}, 32'd0);
`endif

    // Full FIFO with simultaneous pop and push: push accepted.
    do_reset();
    for (int i = 0; i < 32; i++) strobe(14'(i * 211 + 7));
    strobe(14'h1234);
    axis.M_AXIS_TREADY = 1'b1;
    strobe(14'h2345);
    axis.M_AXIS_TREADY = 1'b0;
    chk("sim_no_overflow", {31'd0, overflow}, 32'd0);
    drain(40);
    chk("sim_no_overflow_end", {31'd0, overflow}, 32'd0);

    // ENABLE drop discards the orphan sample and ignores strobes while low.
    do_reset();
    axis.M_AXIS_TREADY = 1'b1;
    strobe(14'h0123);
    enable = 1'b0;
    mhalf = 1'b0;
    strobe(14'h0456);
    step();
    step();
    enable = 1'b1;
    chk("en_nothing", {31'd0, axis.M_AXIS_TVALID}, 32'd0);
    strobe(14'h2000);
    strobe(14'h3FFF);
    chk("en_tvalid", {31'd0, axis.M_AXIS_TVALID}, 32'd1);
    chk("en_tdata", axis.M_AXIS_TDATA, 32'h1FFF0000);
    step();
    chk("en_done", {31'd0, axis.M_AXIS_TVALID}, 32'd0);
    axis.M_AXIS_TREADY = 1'b0;

    // Reset mid-packet: outputs clear at once, next packet is full length.
    do_reset();
    for (int i = 0; i < 12; i++) strobe(14'(i * 333 + 11));
    axis.M_AXIS_TREADY = 1'b1;
    step();
    step();
    axis.M_AXIS_TREADY = 1'b0;
    chk("mid_tvalid_pre", {31'd0, axis.M_AXIS_TVALID}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    mhalf = 1'b0;
    #1;
    chk("mid_tvalid", {31'd0, axis.M_AXIS_TVALID}, 32'd0);
    chk("mid_tlast", {31'd0, axis.M_AXIS_TLAST}, 32'd0);
    chk("mid_tdata", axis.M_AXIS_TDATA, 32'd0);
    chk("mid_overflow", {31'd0, overflow}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    last_cnt = 0;
    for (int i = 0; i < 8; i++) strobe(14'(i * 1500 + 1));
    drain(20);
    chk("mid_lasts", 32'(last_cnt), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
